// File: rtl/dmem_axil_bridge.sv
// dmem_axil_bridge: single-beat dmem port to AXI4-Lite master with byte-lane steering.
// Define DMEM_TIMEOUT_EN to add a response watchdog of TIMEOUT_CYCLES.
module dmem_axil_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   dmem_addr,
   input  logic [DATA_WIDTH-1:0]   dmem_write_data,
   input  logic                    dmem_read,
   input  logic                    dmem_write,
   input  logic [DATA_WIDTH/8-1:0] dmem_byte_enable,
   output logic [DATA_WIDTH-1:0]   dmem_read_data,
   output logic                    dmem_ready,
   output logic                    dmem_error,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);
   typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, RESP} state_t;
   state_t state_q, state_d;
   logic [ADDR_WIDTH-3:0]   addr_q, addr_d;
   logic [1:0]              off_q, off_d;
   logic [DATA_WIDTH/8-1:0] be_q, be_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic aw_done_q, aw_done_d, w_done_q, w_done_d, err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_sh, lane_mask;
   logic req, tmo, late_b, late_r;
   assign req = dmem_read | dmem_write;
`ifdef DMEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic busy;
   assign busy   = state_q inside {WR, WR_B, RD_A, RD_D};
   assign tmo    = busy && cnt_q == CW'(TIMEOUT_CYCLES - 1);
   assign cnt_d  = (busy && state_d == state_q) ? cnt_q + 1'b1 : '0;
   // a response abandoned by the watchdog is drained and dropped in IDLE
   assign late_b = state_q == IDLE && m_axi_bvalid;
   assign late_r = state_q == IDLE && m_axi_rvalid;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
`else
   assign tmo    = 1'b0;
   assign late_b = 1'b0;
   assign late_r = 1'b0;
`endif
   assign rdata_sh  = m_axi_rdata >> {off_q, 3'b000};
   assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      off_d     = off_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      err_d     = err_q;
      case (state_q)
         IDLE: if (req) begin
            addr_d    = dmem_addr[ADDR_WIDTH-1:2];
            off_d     = dmem_addr[1:0];
            be_d      = dmem_byte_enable;
            wdata_d   = dmem_write_data;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            err_d     = dmem_read & dmem_write;
            state_d   = dmem_write ? WR : RD_A;
         end
         WR: begin
            aw_done_d = aw_done_q | m_axi_awready;
            w_done_d  = w_done_q | m_axi_wready;
            state_d   = (aw_done_d && w_done_d) ? WR_B : WR;
         end
         WR_B: if (m_axi_bvalid) begin
            err_d   = err_q | (m_axi_bresp != 2'b00);
            state_d = RESP;
         end
         RD_A: state_d = m_axi_arready ? RD_D : RD_A;
         RD_D: if (m_axi_rvalid) begin
            rdata_d = rdata_sh & lane_mask;
            err_d   = err_q | (m_axi_rresp != 2'b00);
            state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (tmo) begin
         state_d = RESP;
         err_d   = 1'b1;
         rdata_d = '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         off_q     <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         off_q     <= off_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         err_q     <= err_d;
      end
   // valids come only from registered state, never from the ready inputs
   assign m_axi_awaddr   = {addr_q, 2'b00};
   assign m_axi_araddr   = {addr_q, 2'b00};
   assign m_axi_awprot   = 3'b000;
   assign m_axi_arprot   = 3'b000;
   assign m_axi_awvalid  = state_q == WR && !aw_done_q;
   assign m_axi_wvalid   = state_q == WR && !w_done_q;
   assign m_axi_wdata    = wdata_q << {off_q, 3'b000};
   assign m_axi_wstrb    = be_q << off_q;
   assign m_axi_bready   = state_q == WR_B || late_b;
   assign m_axi_arvalid  = state_q == RD_A;
   assign m_axi_rready   = state_q == RD_D || late_r;
   assign dmem_ready     = (state_q == IDLE && !req) || state_q == RESP;
   assign dmem_error     = state_q == RESP && err_q;
   assign dmem_read_data = rdata_q;
endmodule

// File: tb/tb_dmem_axil_bridge.sv
// tb_dmem_axil_bridge: vector table driven through a core-side driver, with a delay-programmable AXI-Lite slave.
module tb_dmem_axil_bridge;
   localparam int TO = `ifdef DMEM_TIMEOUT_EN 8 `else 256 `endif;
   logic clk = 1'b0, rst_n = 1'b1;
   logic [31:0] dmem_addr = '0, dmem_write_data = '0, dmem_read_data;
   logic dmem_read = 1'b0, dmem_write = 1'b0, dmem_ready, dmem_error;
   logic [3:0] dmem_byte_enable = '0;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic [2:0] m_axi_awprot, m_axi_arprot;
   logic [3:0] m_axi_wstrb;
   logic [1:0] m_axi_bresp, m_axi_rresp;
   logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
   logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
   always #5 clk = ~clk;
   dmem_axil_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data),
      .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
      .dmem_read_data(dmem_read_data), .dmem_ready(dmem_ready), .dmem_error(dmem_error),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
      .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );
   int aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
   logic [31:0] s_rdata = '0;
   logic [1:0] s_resp = '0;
   int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
   int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0;
   logic aw_seen = 1'b0, w_seen = 1'b0, r_pend = 1'b0;
   logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
   logic [3:0] cap_wstrb = '0;
   assign m_axi_awready = m_axi_awvalid && aw_c >= aw_d;
   assign m_axi_wready  = m_axi_wvalid && w_c >= w_d;
   assign m_axi_arready = m_axi_arvalid && ar_c >= ar_d;
   assign m_axi_bvalid  = aw_seen && w_seen && b_c >= b_d;
   assign m_axi_rvalid  = r_pend && r_c >= r_d;
   assign m_axi_rdata   = s_rdata;
   assign m_axi_rresp   = s_resp;
   assign m_axi_bresp   = s_resp;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         aw_c <= 0; w_c <= 0; b_c <= 0; ar_c <= 0; r_c <= 0;
         aw_seen <= 1'b0; w_seen <= 1'b0; r_pend <= 1'b0;
      end else begin
         aw_c <= (m_axi_awvalid && !m_axi_awready) ? aw_c + 1 : 0;
         w_c  <= (m_axi_wvalid && !m_axi_wready) ? w_c + 1 : 0;
         ar_c <= (m_axi_arvalid && !m_axi_arready) ? ar_c + 1 : 0;
         if (m_axi_awvalid && m_axi_awready) begin
            aw_seen <= 1'b1; cap_awaddr <= m_axi_awaddr; aw_n <= aw_n + 1;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            w_seen <= 1'b1; cap_wdata <= m_axi_wdata; cap_wstrb <= m_axi_wstrb; w_n <= w_n + 1;
         end
         if (m_axi_bvalid && m_axi_bready) begin
            aw_seen <= 1'b0; w_seen <= 1'b0; b_c <= 0; b_n <= b_n + 1;
         end else if (aw_seen && w_seen) b_c <= b_c + 1;
         if (m_axi_arvalid && m_axi_arready) begin
            r_pend <= 1'b1; cap_araddr <= m_axi_araddr; ar_n <= ar_n + 1;
         end
         if (m_axi_rvalid && m_axi_rready) begin
            r_pend <= 1'b0; r_c <= 0;
         end else if (r_pend) r_c <= r_c + 1;
      end
   // protocol monitor: a pending valid must persist with stable payload, prot is always 0
   logic pa = 1'b0, pw = 1'b0, pr = 1'b0;
   logic [31:0] paa = '0, pwd = '0, pra = '0;
   int viol = 0;
   always @(posedge clk)
      if (!rst_n) begin
         pa <= 1'b0; pw <= 1'b0; pr <= 1'b0;
      end else begin
         if ((pa && (!m_axi_awvalid || m_axi_awaddr != paa)) || (pw && (!m_axi_wvalid || m_axi_wdata != pwd)) ||
             (pr && (!m_axi_arvalid || m_axi_araddr != pra)) || (m_axi_awvalid && m_axi_awprot != 3'b000) ||
             (m_axi_arvalid && m_axi_arprot != 3'b000))
            viol <= viol + 1;
         pa <= m_axi_awvalid && !m_axi_awready; paa <= m_axi_awaddr;
         pw <= m_axi_wvalid && !m_axi_wready;   pwd <= m_axi_wdata;
         pr <= m_axi_arvalid && !m_axi_arready; pra <= m_axi_araddr;
      end
   typedef struct {
      logic rd, wr;
      logic [31:0] addr;
      logic [3:0] be;
      logic [31:0] wdata, sdata;
      logic [1:0] resp;
      int aw_d, w_d, b_d, ar_d, r_d;
      logic [31:0] e_axaddr;
      logic [3:0] e_wstrb;
      logic [31:0] e_wdata, e_rdata;
      logic e_err;
      int e_lat, e_av, e_wv, e_naw, e_nar;
   } vec_t;
   typedef struct {logic [31:0] rdata; logic err; logic rd;} sb_t;
   vec_t vecs[$];
   sb_t sbq[$];
   int pass_n = 0, tot_n = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask
   function automatic string nm(input int id, input string s);
      return $sformatf("v%0d_%s", id, s);
   endfunction
   task automatic run_vec(input int id, input vec_t v);
      sb_t e;
      int lat, av, wv, naw, nar, nb;
      bit done;
      aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d; ar_d = v.ar_d; r_d = v.r_d;
      s_rdata = v.sdata; s_resp = v.resp;
      naw = aw_n; nar = ar_n; nb = b_n;
      sbq.push_back('{v.e_rdata, v.e_err, v.rd && !v.wr});
      @(posedge clk); #1;
      dmem_read = v.rd; dmem_write = v.wr; dmem_addr = v.addr;
      dmem_write_data = v.wdata; dmem_byte_enable = v.be;
      lat = 0; av = 0; wv = 0; done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (dmem_ready) done = 1'b1;
         else begin
            lat++; av += int'(m_axi_awvalid); wv += int'(m_axi_wvalid);
         end
      end
      chk(nm(id, "complete"), 32'(done), 32'd1);
      e = sbq.pop_front();
      if (done) begin
         chk(nm(id, "error"), 32'(dmem_error), 32'(e.err));
         if (e.rd) chk(nm(id, "rdata"), dmem_read_data, e.rdata);
      end
      @(posedge clk); #1;
      dmem_read = 1'b0; dmem_write = 1'b0;
      @(negedge clk);
      chk(nm(id, "idle_after"), {30'd0, dmem_ready, dmem_error}, 32'h2);
      chk(nm(id, "latency"), 32'(lat), 32'(v.e_lat));
      chk(nm(id, "awvalid_cycles"), 32'(av), 32'(v.e_av));
      chk(nm(id, "wvalid_cycles"), 32'(wv), 32'(v.e_wv));
      chk(nm(id, "aw_count"), 32'(aw_n - naw), 32'(v.e_naw));
      chk(nm(id, "b_count"), 32'(b_n - nb), 32'(v.e_naw));
      chk(nm(id, "ar_count"), 32'(ar_n - nar), 32'(v.e_nar));
      if (v.e_naw > 0) begin
         chk(nm(id, "awaddr"), cap_awaddr, v.e_axaddr);
         chk(nm(id, "wstrb"), 32'(cap_wstrb), 32'(v.e_wstrb));
         chk(nm(id, "wdata"), cap_wdata, v.e_wdata);
      end
      if (v.e_nar > 0) chk(nm(id, "araddr"), cap_araddr, v.e_axaddr);
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      bit done;
      // rd wr addr be wdata sdata resp | aw w b ar r | axaddr wstrb wdata rdata err | lat av wv naw nar
      vecs.push_back('{1'b1, 1'b0, 32'h1000_0006, 4'h3, 32'h0, 32'hAABB_CCDD, 2'b00, 0, 0, 0, 0, 0,
                       32'h1000_0004, 4'h0, 32'h0, 32'h0000_AABB, 1'b0, 3, 0, 0, 0, 1});
      vecs.push_back('{1'b0, 1'b1, 32'h2000_0003, 4'h1, 32'h0000_005A, 32'h0, 2'b00, 0, 0, 0, 0, 0,
                       32'h2000_0000, 4'h8, 32'h5A00_0000, 32'h0, 1'b0, 3, 1, 1, 1, 0});
      vecs.push_back('{1'b0, 1'b1, 32'h3000_0004, 4'hF, 32'h1234_5678, 32'h0, 2'b00, 4, 0, 0, 0, 0,
                       32'h3000_0004, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 7, 5, 1, 1, 0});
      vecs.push_back('{1'b1, 1'b0, 32'h4000_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, 0,
                       32'h4000_0000, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 3, 0, 0, 0, 1});
      vecs.push_back('{1'b1, 1'b1, 32'h5000_0001, 4'h3, 32'h0000_BEEF, 32'h0, 2'b00, 0, 0, 0, 0, 0,
                       32'h5000_0000, 4'h6, 32'h00BE_EF00, 32'h0, 1'b1, 3, 1, 1, 1, 0});
      vecs.push_back('{1'b1, 1'b0, 32'h6000_0003, 4'h1, 32'h0, 32'h1122_3344, 2'b00, 0, 0, 0, 2, 3,
                       32'h6000_0000, 4'h0, 32'h0, 32'h0000_0011, 1'b0, 8, 0, 0, 0, 1});
      vecs.push_back('{1'b1, 1'b0, 32'h7000_0001, 4'h3, 32'h0, 32'h8899_AABB, 2'b00, 0, 0, 0, 0, 0,
                       32'h7000_0000, 4'h0, 32'h0, 32'h0000_99AA, 1'b0, 3, 0, 0, 0, 1});
      vecs.push_back('{1'b0, 1'b1, 32'h8000_0002, 4'h3, 32'hFFFF_CAFE, 32'h0, 2'b00, 0, 3, 2, 0, 0,
                       32'h8000_0000, 4'hC, 32'hCAFE_0000, 32'h0, 1'b0, 8, 1, 4, 1, 0});
      vecs.push_back('{1'b0, 1'b1, 32'h9000_0000, 4'hF, 32'h0BAD_F00D, 32'h0, 2'b11, 0, 0, 0, 0, 0,
                       32'h9000_0000, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b1, 3, 1, 1, 1, 0});
      vecs.push_back('{1'b1, 1'b0, 32'hA000_0002, 4'h1, 32'h0, 32'h55C3_0000, 2'b00, 0, 0, 0, 0, 0,
                       32'hA000_0000, 4'h0, 32'h0, 32'h0000_00C3, 1'b0, 3, 0, 0, 0, 1});
      vecs.push_back('{1'b0, 1'b1, 32'hB000_0001, 4'h1, 32'h0000_0077, 32'h0, 2'b00, 2, 2, 0, 0, 0,
                       32'hB000_0000, 4'h2, 32'h0000_7700, 32'h0, 1'b0, 5, 3, 3, 1, 0});
`ifdef DMEM_TIMEOUT_EN
      vecs.push_back('{1'b1, 1'b0, 32'hC000_0000, 4'hF, 32'h0, 32'h1111_1111, 2'b00, 0, 0, 0, 1000, 0,
                       32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 9, 0, 0, 0, 0});
`endif
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready_err", {30'd0, dmem_ready, dmem_error}, 32'h2);
      chk("reset_rdata", dmem_read_data, 32'h0);
      chk("reset_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      foreach (vecs[i]) run_vec(i, vecs[i]);
      // reset while waiting for read data
      aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 50; s_rdata = 32'hFACE_0000; s_resp = 2'b00;
      @(posedge clk); #1;
      dmem_read = 1'b1; dmem_addr = 32'h1000_0000; dmem_byte_enable = 4'hF;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (m_axi_rready) done = 1'b1;
      end
      chk("rst_mid_reached_rd_d", 32'(done), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'h0);
      dmem_read = 1'b0;
      #1 chk("rst_mid_ready_err", {30'd0, dmem_ready, dmem_error}, 32'h2);
      chk("rst_mid_rdata", dmem_read_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_mid_idle", {28'd0, dmem_ready, dmem_error, m_axi_arvalid, m_axi_rready}, 32'h8);
      run_vec(100, vecs[0]);
      chk("axi_stability", 32'(viol), 32'd0);
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule

// File: doc/dmem_axil_bridge.md
Name: dmem_axil_bridge

Overview:
- Converts the CPU core's single-beat data-memory request port (addr/wdata/read/write/byte_enable/ready) into an AXI4-Lite master for the Zynq PS/PL interconnect.
- Sits directly downstream of the CPU top's dmem interface.
- Performs byte-lane steering on writes and reads, and holds dmem_ready low for the whole transaction so the core stalls.

Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- DATA_WIDTH, 32, data width on both sides; only 32 is supported.
- TIMEOUT_CYCLES, 256, response watchdog limit (used only with DMEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- dmem_addr  in  32  byte address from core
- dmem_write_data  in  32  store data, LSB-aligned
- dmem_read  in  1  load request
- dmem_write  in  1  store request
- dmem_byte_enable  in  4  LSB-aligned lane mask (1, 3, F)
- dmem_read_data  out  32  load data, LSB-aligned
- dmem_ready  out  1  high = no stall
- dmem_error  out  1  error flag, valid with the completing ready
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  32/3/1/1  AXI write address channel
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  AXI write data channel
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  AXI write response channel
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  32/3/1/1  AXI read address channel
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  AXI read data channel

Behaviour:
- Reset (async, rst_n=0): state IDLE; all valid/ready outputs 0; dmem_read_data 0; dmem_error 0; dmem_ready 1. Reset mid-transaction drops all AXI valids immediately; no completion is signalled.
- dmem_ready is combinational: 1 when (IDLE and no request) or in RESP; 0 otherwise. A request drops it in the same cycle.
- Requests are latched in IDLE: addr, lane offset o=addr[1:0], strobe, data.
- awaddr/araddr = {addr[31:2],2'b00}; awprot = arprot = 3'b000.
- Write steering: wstrb = (be << o) truncated to 4 bits; wdata = wdata << 8*o.
- Read steering: rdata_out = (rdata >> 8*o) with lanes outside the LSB-aligned be forced to 0 (zero-extend; sign extension is the core's job).
- dmem_read and dmem_write both high: write wins, read is dropped, dmem_error=1 on completion.
- FSM:
  - IDLE -> WR on write, -> RD_A on read.
  - WR: awvalid and wvalid asserted together; each deasserts independently on its own handshake. Either order and same-cycle acceptance are legal. Exit to WR_B when both are done.
  - WR_B: bready=1; bvalid -> RESP.
  - RD_A: arvalid until arready -> RD_D.
  - RD_D: rready=1; rvalid -> capture steered rdata -> RESP.
  - RESP: one cycle; dmem_ready=1; dmem_error = (resp != OKAY) or dual-request; -> IDLE.
- dmem_read_data holds its last captured value until the next read completes.
- A request still asserted in the cycle after RESP is a new transaction; the core must advance on the RESP cycle.
- Latency with zero-wait slave: write 3 cycles (WR, WR_B, RESP); read 3 cycles (RD_A, RD_D, RESP).
- Valid outputs never depend combinationally on ready inputs; once asserted, address/data stay stable until the handshake.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - A counter runs in WR, WR_B, RD_A and RD_D, and clears on every state change.
  - Reaching TIMEOUT_CYCLES forces RESP with dmem_error=1 and read data 0, dropping all valids.
  - A late bvalid/rvalid arriving in IDLE is accepted (ready held 1 for one cycle) and discarded.
- Undefined: no counter; the bridge waits indefinitely.

Test Plan:
- Read addr 0x1000_0006, be=3, slave rdata 0xAABB_CCDD zero-wait -> araddr 0x1000_0004; after 3 cycles dmem_read_data=0x0000_AABB, error=0.
- Write addr 0x2000_0003, be=1, wdata 0x0000_005A -> awaddr 0x2000_0000, wstrb 4'h8, wdata 0x5A00_0000; ready returns after bvalid.
- awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held with stable address; exactly one B; single RESP.
- Slave returns rresp=2'b10 -> RESP cycle shows dmem_error=1, ready=1; next cycle error=0.
- read=write=1 -> only AW/W issued, no AR; completion dmem_error=1.
- rst_n low during RD_D -> arvalid/rready 0 asynchronously; after release state IDLE, ready=1. With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never asserting arready -> RESP after 8 cycles with error=1.
